uart_rx_wb: RTL and testbench



---
 rtl/uart_rx_wb_pkg.sv | 31 +++
 rtl/uart_rx_wb_sync_fifo.sv | 58 +++++
 rtl/uart_rx_wb.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_wb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_wb_pkg.sv
// Shared constants for the Wishbone UART receiver:
// register map, STATUS layout, FSM encoding and divisor floor.
package uart_rx_wb_pkg;

    localparam logic [3:0] OFS_RXDATA  = 4'h0;
    localparam logic [3:0] OFS_STATUS  = 4'h4;
    localparam logic [3:0] OFS_DIVISOR = 4'h8;
    localparam logic [3:0] OFS_IRQ_EN  = 4'hC;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT     = 8;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t S_IDLE  = 2'd0;
    localparam rx_state_t S_START = 2'd1;
    localparam rx_state_t S_DATA  = 2'd2;
    localparam rx_state_t S_STOP  = 2'd3;

    localparam logic [15:0] MIN_DIV = 16'd4;

    function automatic logic [15:0] clamp_div(
        input logic [15:0] d
    );
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_rx_wb_sync_fifo.sv
// Synchronous FIFO with combinational head output.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with RX FIFO, exposed as a
// Wishbone responder with a level interrupt.
module uart_rx_wb
    import uart_rx_wb_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic        wb_ack,
    output logic        irq,
    input  logic        uart_rx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    logic            rx_fall;

    rx_state_t       state;
    logic [15:0]     clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            cnt_zero;
    logic            stop_hit;

    logic [15:0]     divisor;
    logic            irq_en;
    logic            overrun;
    logic            frame_err;

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    logic            req;
    logic            wr;
    logic            rd;
    logic            sel_rx;
    logic            sel_st;
    logic            sel_div;
    logic            sel_ien;
    logic [31:0]     status_word;
    logic [31:0]     rd_word;
    logic            unused_bits;

    assign unused_bits = ^{wb_sel, wb_adr[31:4],
                           wb_adr[1:0], wb_data_w[31:16]};

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Edge-only start detect: a held break needs a rise first.
    assign rx_fall  = rx_prev & ~rx_s2;
    assign cnt_zero = (clk_cnt == 16'd0);
    assign stop_hit = (state == S_STOP) & cnt_zero;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fall) begin
                        state   <= S_START;
                        clk_cnt <= (divisor >> 1) - 16'd1;
                    end
                end
                S_START: begin
                    if (!cnt_zero) begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end else if (!rx_s2) begin
                        state   <= S_DATA;
                        clk_cnt <= divisor - 16'd1;
                        bit_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!cnt_zero) begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end else begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        clk_cnt <= divisor - 16'd1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!cnt_zero) begin
                        clk_cnt <= clk_cnt - 16'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fifo_push = stop_hit & rx_s2 & ~fifo_full;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (shreg),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign req     = wb_cyc & wb_stb & ~wb_ack;
    assign wr      = req & wb_we;
    assign rd      = req & ~wb_we;
    assign sel_rx  = (wb_adr[3:2] == OFS_RXDATA[3:2]);
    assign sel_st  = (wb_adr[3:2] == OFS_STATUS[3:2]);
    assign sel_div = (wb_adr[3:2] == OFS_DIVISOR[3:2]);
    assign sel_ien = (wb_adr[3:2] == OFS_IRQ_EN[3:2]);

    assign fifo_pop = rd & sel_rx;
    assign irq      = irq_en & ~fifo_empty;

    always_comb begin
        status_word = '0;
        status_word[ST_NOT_EMPTY] = ~fifo_empty;
        status_word[ST_FULL]      = fifo_full;
        status_word[ST_OVERRUN]   = overrun;
        status_word[ST_FRAME_ERR] = frame_err;
        status_word[ST_COUNT +: 8] = 8'(fifo_count);
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            sel_rx: begin
                if (!fifo_empty) begin
                    rd_word = {23'd0, 1'b1, fifo_dout};
                end
            end
            sel_st:  rd_word = status_word;
            sel_div: rd_word = {16'd0, divisor};
            sel_ien: rd_word = {31'd0, irq_en};
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_ack    <= 1'b0;
            wb_data_r <= '0;
            divisor   <= CLKS_PER_BIT;
            irq_en    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wb_ack <= req;
            if (req) begin
                wb_data_r <= rd_word;
            end
            if (wr && sel_div) begin
                divisor <= clamp_div(wb_data_w[15:0]);
            end
            if (wr && sel_ien) begin
                irq_en <= wb_data_w[0];
            end
            // A new error wins over a same-cycle clear so it is not lost.
            if (stop_hit && rx_s2 && fifo_full) begin
                overrun <= 1'b1;
            end else if (wr && sel_st && wb_data_w[ST_OVERRUN]) begin
                overrun <= 1'b0;
            end
            if (stop_hit && !rx_s2) begin
                frame_err <= 1'b1;
            end else if (wr && sel_st && wb_data_w[ST_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Self-checking bench for uart_rx_wb: register table,
// byte scoreboard and multi-cycle corner sequences.
module tb_uart_rx_wb;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_data_w;
    logic [31:0] wb_data_r;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        irq;
    logic        uart_rx;

    int n_checks = 0;
    int n_fail   = 0;
    int div_tb   = 16;

    logic [7:0] sb [$];

    typedef struct {
        string       name;
        logic [3:0]  adr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [12];

    uart_rx_wb #(
        .CLKS_PER_BIT (16'd434),
        .FIFO_DEPTH   (8)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wb_adr    (wb_adr),
        .wb_data_w (wb_data_w),
        .wb_data_r (wb_data_r),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_ack    (wb_ack),
        .irq       (irq),
        .uart_rx   (uart_rx)
    );

    always #5 wb_clk = ~wb_clk;

    function automatic void check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     name, act, exp);
        end
    endfunction

    task automatic wb_xfer(
        input  logic [3:0]  adr,
        input  logic        we,
        input  logic [31:0] wd,
        output logic [31:0] rdata
    );
        logic got;
        got   = 1'b0;
        rdata = '0;
        @(negedge wb_clk);
        wb_adr    = {28'd0, adr};
        wb_we     = we;
        wb_data_w = wd;
        wb_cyc    = 1'b1;
        wb_stb    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge wb_clk);
            #1;
            if (wb_ack) begin
                got   = 1'b1;
                rdata = wb_data_r;
                break;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, wd, dummy);
    endtask

    task automatic read_chk(
        input string name, input logic [3:0] adr, input logic [31:0] exp
    );
        logic [31:0] r;
        wb_xfer(adr, 1'b0, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic read_rx(input string name);
        logic [31:0] r;
        logic [31:0] exp;
        exp = '0;
        if (sb.size() > 0) begin
            exp = {23'd0, 1'b1, sb.pop_front()};
        end
        wb_xfer(4'h0, 1'b0, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic send_frame(
        input logic [7:0] b, input logic stop, input logic expect_push
    );
        if (expect_push) begin
            sb.push_back(b);
        end
        @(negedge wb_clk);
        uart_rx = 1'b0;
        repeat (div_tb) @(posedge wb_clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk);
            uart_rx = b[i];
            repeat (div_tb) @(posedge wb_clk);
        end
        @(negedge wb_clk);
        uart_rx = stop;
        repeat (div_tb) @(posedge wb_clk);
        @(negedge wb_clk);
        uart_rx = 1'b1;
        repeat (div_tb) @(posedge wb_clk);
    endtask

    task automatic wait_irq(input logic level, input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge wb_clk);
            #1;
            if (irq == level) begin
                break;
            end
        end
        check(name, {31'd0, irq}, {31'd0, level});
    endtask

    initial begin
        logic [31:0] r;
        int acks;

        vt[0]  = '{"rst_rxdata",  4'h0, 1'b0, 32'd0,        32'h0};
        vt[1]  = '{"rst_status",  4'h4, 1'b0, 32'd0,        32'h0};
        vt[2]  = '{"rst_divisor", 4'h8, 1'b0, 32'd0,        32'd434};
        vt[3]  = '{"rst_irq_en",  4'hC, 1'b0, 32'd0,        32'h0};
        vt[4]  = '{"wr_div_2",    4'h8, 1'b1, 32'd2,        32'h0};
        vt[5]  = '{"div_clamp",   4'h8, 1'b0, 32'd0,        32'd4};
        vt[6]  = '{"wr_div_16",   4'h8, 1'b1, 32'h5555_0010, 32'h0};
        vt[7]  = '{"div_16",      4'h8, 1'b0, 32'd0,        32'd16};
        vt[8]  = '{"wr_irq_en",   4'hC, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vt[9]  = '{"irq_en_1",    4'hC, 1'b0, 32'd0,        32'd1};
        vt[10] = '{"wr_status",   4'h4, 1'b1, 32'hFFFF_FFFF, 32'h0};
        vt[11] = '{"status_ro",   4'h4, 1'b0, 32'd0,        32'h0};

        wb_rst    = 1'b1;
        wb_adr    = '0;
        wb_data_w = '0;
        wb_we     = 1'b0;
        wb_sel    = 4'hF;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
        uart_rx   = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_ack",    {31'd0, wb_ack}, 32'd0);
        check("rst_data_r", wb_data_r,       32'd0);
        check("rst_irq",    {31'd0, irq},    32'd0);
        @(negedge wb_clk);
        wb_rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wb_xfer(vt[i].adr, vt[i].we, vt[i].wd, r);
            if (!vt[i].we) begin
                check(vt[i].name, r, vt[i].exp);
            end
        end

        // single byte with interrupt
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_irq(1'b1, "irq_rise");
        read_chk("a5_status", 4'h4, 32'h101);
        read_rx("a5_rxdata");
        read_chk("a5_empty", 4'h4, 32'h0);
        #1;
        check("irq_fall", {31'd0, irq}, 32'd0);

        // overrun: nine bytes into eight entries
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, i < 8);
        end
        read_chk("ovr_status", 4'h4, 32'h807);
        for (int i = 0; i < 8; i++) begin
            read_rx("ovr_drain");
        end
        wb_write(4'h4, 32'h4);
        read_chk("ovr_clear", 4'h4, 32'h0);

        // framing error then good byte
        send_frame(8'h3C, 1'b0, 1'b0);
        read_chk("fe_status", 4'h4, 32'h8);
        wb_write(4'h4, 32'h8);
        send_frame(8'h55, 1'b1, 1'b1);
        read_chk("fe_next_st", 4'h4, 32'h101);
        read_rx("fe_next_rx");

        // short glitch must not start a frame
        @(negedge wb_clk);
        uart_rx = 1'b0;
        repeat (4) @(posedge wb_clk);
        @(negedge wb_clk);
        uart_rx = 1'b1;
        repeat (40) @(posedge wb_clk);
        read_chk("glitch_st", 4'h4, 32'h0);

        // reset in the middle of a frame
        send_frame(8'h11, 1'b1, 1'b1);
        @(negedge wb_clk);
        uart_rx = 1'b0;
        repeat (40) @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b1;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst  = 1'b0;
        uart_rx = 1'b1;
        sb.delete();
        repeat (20) @(posedge wb_clk);
        read_chk("mid_rst_st",  4'h4, 32'h0);
        read_chk("mid_rst_div", 4'h8, 32'd434);
        read_chk("mid_rst_ien", 4'hC, 32'h0);
        wb_write(4'h8, 32'd16);
        send_frame(8'h81, 1'b1, 1'b1);
        read_chk("post_rst_st", 4'h4, 32'h101);
        read_rx("post_rst_rx");

        // strobe held through the ack cycle
        acks = 0;
        @(negedge wb_clk);
        wb_adr = 32'hC;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        repeat (2) begin
            @(posedge wb_clk);
            #1;
            acks += int'(wb_ack);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge wb_clk);
        #1;
        acks += int'(wb_ack);
        check("single_ack", 32'(acks), 32'd1);

        // pop lands on the push edge with three entries queued
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hC0 + 8'(i), 1'b1, 1'b1);
        end
        fork
            send_frame(8'h44, 1'b1, 1'b1);
            begin
                @(negedge wb_clk);
                repeat (9 * div_tb + div_tb / 2 + 2) @(posedge wb_clk);
                read_rx("pp_pop");
            end
        join
        read_chk("pp_count", 4'h4, 32'h301);
        for (int i = 0; i < 3; i++) begin
            read_rx("pp_drain");
        end
        read_chk("pp_empty", 4'h4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
